timed_event_dispatcher: RTL
===========================

// Module: timed_event_dispatcher
// PURPOSE
// Consumer-side endpoint of the buffered timeline fan-out: takes one counter/auto_start copy and releases
// queued events exactly when the timeline reaches their timestamp. Software/AXI logic pushes
// (timestamp, payload) pairs into a FIFO; while auto_start is high the head entry fires when
// counter_I reaches its timestamp. Output drives one downstream channel (DDS/TTL sequencer).
// PARAMETERS
// DATA_WIDTH  64  payload width in bits
// DEPTH       16  FIFO entries; power of 2, >=2
// PORTS
// s_axi_aclk      in   1           sole clock
// s_axi_areset    in   1           synchronous, active-high reset
// counter_I       in   64          global timeline counter (buffered copy)
// auto_start_I    in   1           timeline running; dispatch enabled while high
// wr_valid_I      in   1           push request
// wr_ready_O      out  1           push accepted when wr_valid_I & wr_ready_O
// wr_timestamp_I  in   64          event timestamp
// wr_data_I       in   DATA_WIDTH  event payload
// flush_I         in   1           discard all queued entries
// clear_err_I     in   1           clear sticky late_err_O
// event_valid_O   out  1           one-cycle event strobe
// event_data_O    out  DATA_WIDTH  payload of fired event (valid with strobe)
// event_late_O    out  1           fired event was late (valid with strobe)
// late_err_O      out  1           sticky: a late event has fired
// fifo_empty_O    out  1           no entries queued
// fifo_full_O     out  1           DEPTH entries queued
// count_O         out  clog2(DEPTH)+1  entries queued
// BEHAVIOUR
// - Reset (cycle after s_axi_areset sampled high): FIFO empty, state IDLE; event_valid_O=0,
//   event_data_O=0, event_late_O=0, late_err_O=0, fifo_empty_O=1, fifo_full_O=0, count_O=0, wr_ready_O=1.
//   Reset mid-dispatch drops pending strobe and all entries.
// - FIFO: wr_ready_O = !fifo_full_O (registered). Push stores {ts,data}; entry visible as head the cycle after push.
//   Push+pop same cycle: count unchanged. Full: push refused even if pop occurs that cycle.
// - FSM, 2 states: IDLE -> RUN when auto_start_I=1; RUN -> IDLE when auto_start_I=0. No pops in IDLE;
//   pushes accepted in both states; FIFO contents preserved across IDLE/RUN.
// - Dispatch (RUN, FIFO non-empty, auto_start_I=1): head fires in cycle N if counter_I >= head_ts (unsigned 64-bit,
//   no wrap handling). Head popped in cycle N; event_valid_O=1, event_data_O=head data,
//   event_late_O=(counter_I > head_ts) in cycle N+1. Latency counter match -> strobe: 1 cycle.
// - Max one event per cycle. Equal timestamps: first fires on-time, next fires following cycle with event_late_O=1.
// - Timestamp already past at push: fires on first RUN cycle it is head, flagged late.
// - event_data_O holds last fired payload between strobes; event_late_O is 0 when no strobe.
// - late_err_O sets on any late strobe; clear_err_I clears it; set wins over simultaneous clear.
// - flush_I: highest priority after reset; that cycle's push and pop ignored, FIFO empty next cycle,
//   no strobe next cycle; late_err_O unaffected.
// TESTING
// - Reset, auto_start_I=0, push ts=100/data=0xA -> count_O=1, no strobe with counter sweeping 0..200.
// - auto_start_I=1, counter 95..105, head ts=100 -> strobe exactly one cycle after counter=100, data=0xA, late=0.
// - Push ts=50,50,60; counter runs from 48 -> strobes after counter=50 (late=0), 51 (late=1), 60 (late=0); late_err_O=1.
// - Fill DEPTH=16 entries -> fifo_full_O=1, wr_ready_O=0, 17th push refused; one pop -> wr_ready_O=1 next cycle.
// - flush_I with 5 queued while counter matches head -> no strobe, fifo_empty_O=1, count_O=0.
// - Assert s_axi_areset with late_err_O=1 and 3 queued -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/timed_event_dispatcher_if.sv
// Push and event channels of the timed event dispatcher.
// The master side (software/AXI bridge or bench) pushes (timestamp, payload) pairs
// and observes the event strobe. The slave side is the dispatcher itself.
interface timed_event_dispatcher_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  wr_valid_I;
    logic                  wr_ready_O;
    logic [63:0]           wr_timestamp_I;
    logic [DATA_WIDTH-1:0] wr_data_I;
    logic                  event_valid_O;
    logic [DATA_WIDTH-1:0] event_data_O;
    logic                  event_late_O;

    modport master (
        output wr_valid_I,
        output wr_timestamp_I,
        output wr_data_I,
        input  wr_ready_O,
        input  event_valid_O,
        input  event_data_O,
        input  event_late_O
    );

    modport slave (
        input  wr_valid_I,
        input  wr_timestamp_I,
        input  wr_data_I,
        output wr_ready_O,
        output event_valid_O,
        output event_data_O,
        output event_late_O
    );
endinterface

// File: rtl/timed_event_dispatcher.sv
// Timed event dispatcher: a FIFO of (timestamp, payload) entries whose head is
// released as a one-cycle strobe when the buffered timeline counter reaches the
// head timestamp while the timeline is running. Late releases are flagged and
// latched in a sticky error bit. All outputs come straight from registers.
module timed_event_dispatcher #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16
) (
    input  logic                         s_axi_aclk,
    input  logic                         s_axi_areset,
    input  logic [63:0]                  counter_I,
    input  logic                         auto_start_I,
    input  logic                         flush_I,
    input  logic                         clear_err_I,
    timed_event_dispatcher_if.slave      bus,
    output logic                         late_err_O,
    output logic                         fifo_empty_O,
    output logic                         fifo_full_O,
    output logic [$clog2(DEPTH):0]       count_O
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next_s;

    logic [63:0]           ts_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW-1:0]         wr_ptr_next_s;
    logic [AW-1:0]         rd_ptr_next_s;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  ready_r;

    logic                  ev_valid_r;
    logic [DATA_WIDTH-1:0] ev_data_r;
    logic                  ev_late_r;
    logic                  late_err_r;

    logic [63:0]           head_ts_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  late_s;

    // Head entry view plus push/pop decisions; flush suppresses both.
    always_comb begin
        head_ts_s   = ts_mem[rd_ptr_r];
        head_data_s = data_mem[rd_ptr_r];
        // ready_r is !full, so a full FIFO refuses a push even if it pops this cycle
        push_s = bus.wr_valid_I & ready_r & ~flush_I;
        pop_s  = (state_r == RUN) & auto_start_I & ~empty_r
                 & (counter_I >= head_ts_s) & ~flush_I;
        late_s = pop_s & (counter_I > head_ts_s);
    end

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        if (flush_I) begin
            wr_ptr_next_s = {AW{1'b0}};
            rd_ptr_next_s = {AW{1'b0}};
            count_next_s  = {CW{1'b0}};
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally
            if (push_s) begin
                wr_ptr_next_s = wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CW'(1);
                2'b01:   count_next_s = count_r - CW'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Run/idle next-state logic: the state simply follows auto_start_I.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (auto_start_I) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (!auto_start_I) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Entry storage; contents need no reset because the pointers define validity.
    always_ff @(posedge s_axi_aclk) begin
        if (push_s && !s_axi_areset) begin
            ts_mem[wr_ptr_r]   <= bus.wr_timestamp_I;
            data_mem[wr_ptr_r] <= bus.wr_data_I;
        end
    end

    // Pointers, occupancy and the registered full/empty/ready flags.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            ready_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            full_r   <= (count_next_s == CW'(DEPTH));
            empty_r  <= (count_next_s == {CW{1'b0}});
            ready_r  <= (count_next_s != CW'(DEPTH));
        end
    end

    // Event strobe, payload (held between strobes) and late flag.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            ev_valid_r <= 1'b0;
            ev_data_r  <= {DATA_WIDTH{1'b0}};
            ev_late_r  <= 1'b0;
        end else if (flush_I) begin
            ev_valid_r <= 1'b0;
            ev_late_r  <= 1'b0;
        end else begin
            ev_valid_r <= pop_s;
            ev_late_r  <= late_s;
            if (pop_s) begin
                ev_data_r <= head_data_s;
            end
        end
    end

    // Sticky late error; a late release wins over a simultaneous clear.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            late_err_r <= 1'b0;
        end else if (late_s) begin
            late_err_r <= 1'b1;
        end else if (clear_err_I) begin
            late_err_r <= 1'b0;
        end
    end

    assign bus.wr_ready_O    = ready_r;
    assign bus.event_valid_O = ev_valid_r;
    assign bus.event_data_O  = ev_data_r;
    assign bus.event_late_O  = ev_late_r;
    assign late_err_O        = late_err_r;
    assign fifo_empty_O      = empty_r;
    assign fifo_full_O       = full_r;
    assign count_O           = count_r;
endmodule
